// File: rtl/freq_div_pkg.sv
// Shared mode encoding and limits for the programmable frequency divider.
// No logic, no latency.
// No flow control; constants only.
package freq_div_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } div_mode_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_counter_core.sv
// Period counter: wrap detect, terminal-count pulse and clk_out shaping.
// clk_out/tc are registered, one cycle after the counter state that causes them.
// No backpressure; en=0 freezes the counter, clr forces a fresh period start.
module div_counter_core
    import freq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div,
    input  logic             mode,
    output logic             wrap,
    output logic             clk_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   half_n;

    always_comb begin
        // ceil(N/2) needs the extra bit so N = 2^WIDTH-1 does not overflow.
        half_n    = ({1'b0, div} + ONE_W) >> 1;
        wrap      = en && (cnt_q == (div - ONE));
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tc_d      = 1'b0;
        if (clr) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (en) begin
            cnt_d = wrap ? '0 : (cnt_q + ONE);
            tc_d  = wrap;
            if (mode == MODE_SQUARE) begin
                clk_out_d = ({1'b0, cnt_d} < half_n);
            end else begin
                clk_out_d = wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tc_q      <= tc_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tc      = tc_q;

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable clock divider with shadowed ratio/mode, applied at period boundaries.
// load_ack/load_err one cycle after load; new ratio takes effect after the current period.
// No backpressure; later loads overwrite an unapplied one, en=0 freezes the output.
module prog_freq_divider
    import freq_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             mode,
    input  logic             load,
    output logic             load_ack,
    output logic             load_err,
    output logic             clk_out,
    output logic             tc,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] active_div_q, active_div_d;
    div_mode_e        active_mode_q, active_mode_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    div_mode_e        pend_mode_q, pend_mode_d;
    logic             pend_valid_q, pend_valid_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;

    logic             wrap;
    logic             apply;
    logic             clr;
    logic             legal;

    always_comb begin
        legal = (div_val >= MIN_DIV_W);
        // While stopped there is no period to protect, so a pending request lands immediately.
        apply = pend_valid_q && (wrap || !en);
        clr   = pend_valid_q && !en;

        active_div_d  = active_div_q;
        active_mode_d = active_mode_q;
        pend_div_d    = pend_div_q;
        pend_mode_d   = pend_mode_q;
        pend_valid_d  = pend_valid_q;
        load_ack_d    = load && legal;
        load_err_d    = load && !legal;

        if (apply) begin
            active_div_d  = pend_div_q;
            active_mode_d = pend_mode_q;
            pend_valid_d  = 1'b0;
        end
        // A load on the applying edge becomes the next pending request.
        if (load_ack_d) begin
            pend_div_d   = div_val;
            pend_mode_d  = div_mode_e'(mode);
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_div_q  <= DEF_DIV;
            active_mode_q <= MODE_SQUARE;
            pend_div_q    <= DEF_DIV;
            pend_mode_q   <= MODE_SQUARE;
            pend_valid_q  <= 1'b0;
            load_ack_q    <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            active_div_q  <= active_div_d;
            active_mode_q <= active_mode_d;
            pend_div_q    <= pend_div_d;
            pend_mode_q   <= pend_mode_d;
            pend_valid_q  <= pend_valid_d;
            load_ack_q    <= load_ack_d;
            load_err_q    <= load_err_d;
        end
    end

    div_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .div     (active_div_q),
        .mode    (active_mode_q),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tc      (tc)
    );

    assign load_ack = load_ack_q;
    assign load_err = load_err_q;
    assign cur_div  = active_div_q;

endmodule
